// File: rtl/effect_sample_sequencer.sv
// effect_sample_sequencer: codec ADC -> effect stage -> DAC pair sequencer; EFFECT_SAMPLE_SEQ_COUNT_EN adds sample_count.
module effect_sample_sequencer #(
  parameter int unsigned PROC_LATENCY = 2,
  parameter int unsigned WR_TIMEOUT   = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_ready,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read,
  output logic [31:0] l_fx_in,
  output logic [31:0] r_fx_in,
  input  logic [31:0] l_fx_out,
  input  logic [31:0] r_fx_out,
  input  logic        write_ready,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out,
  output logic        write,
  output logic        busy,
  output logic        drop
`ifdef EFFECT_SAMPLE_SEQ_COUNT_EN
  , output logic [31:0] sample_count
`endif
);
  typedef enum logic [1:0] {IDLE, READ, PROC, WRITE} state_t;
  state_t state_q, state_d;
  logic [3:0] lat_q, lat_d;
  logic [15:0] wait_q, wait_d;
  logic [31:0] l_in_q, l_in_d, r_in_q, r_in_d, l_out_q, l_out_d, r_out_q, r_out_d;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q <= '0;
      wait_q <= '0;
      l_in_q <= '0;
      r_in_q <= '0;
      l_out_q <= '0;
      r_out_q <= '0;
    end else begin
      state_q <= state_d;
      lat_q <= lat_d;
      wait_q <= wait_d;
      l_in_q <= l_in_d;
      r_in_q <= r_in_d;
      l_out_q <= l_out_d;
      r_out_q <= r_out_d;
    end
  end
  always_comb begin
    state_d = state_q;
    lat_d = lat_q;
    wait_d = wait_q;
    l_in_d = l_in_q;
    r_in_d = r_in_q;
    l_out_d = l_out_q;
    r_out_d = r_out_q;
    read = 1'b0;
    write = 1'b0;
    drop = 1'b0;
    case (state_q)
      IDLE: state_d = read_ready ? READ : IDLE;
      READ: begin
        read = 1'b1;
        l_in_d = left_channel_audio_in;
        r_in_d = right_channel_audio_in;
        lat_d = 4'(PROC_LATENCY - 1);
        state_d = PROC;
      end
      PROC: begin
        lat_d = lat_q - 4'd1;
        if (lat_q == 4'd0) begin
          lat_d = '0;
          l_out_d = l_fx_out;
          r_out_d = r_fx_out;
          wait_d = '0;
          state_d = WRITE;
        end
      end
      WRITE: begin
        // a ready DAC on the timeout cycle still takes the pair
        write = write_ready;
        drop = !write_ready && wait_q == 16'(WR_TIMEOUT);
        wait_d = (write || drop) ? '0 : wait_q + 16'd1;
        state_d = (write || drop) ? IDLE : WRITE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign busy = state_q != IDLE;
  assign l_fx_in = l_in_q;
  assign r_fx_in = r_in_q;
  assign left_channel_audio_out = l_out_q;
  assign right_channel_audio_out = r_out_q;
`ifdef EFFECT_SAMPLE_SEQ_COUNT_EN
  logic [31:0] count_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else count_q <= count_q + 32'(write);
  end
  assign sample_count = count_q;
`endif
endmodule

// File: tb/tb_effect_sample_sequencer.sv
// tb_effect_sample_sequencer: randomized scoreboard bench with a cycle-level reference of the read/write/drop rules.
module tb_effect_sample_sequencer;
  localparam int PL = 2;
  localparam int TO = 5;
  typedef struct {logic [31:0] l; logic [31:0] r;} pair_t;
  logic clk = 1'b0, reset = 1'b1, read_ready = 1'b0, write_ready = 1'b0, mode = 1'b0;
  logic [31:0] left_in = '0, right_in = '0, l_fx_in, r_fx_in, l_fx_out, r_fx_out, left_out, right_out;
  logic read, write, busy, drop;
`ifdef EFFECT_SAMPLE_SEQ_COUNT_EN
  logic [31:0] sample_count;
`endif
  effect_sample_sequencer #(.PROC_LATENCY(PL), .WR_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .read_ready(read_ready),
    .left_channel_audio_in(left_in), .right_channel_audio_in(right_in),
    .read(read), .l_fx_in(l_fx_in), .r_fx_in(r_fx_in),
    .l_fx_out(l_fx_out), .r_fx_out(r_fx_out), .write_ready(write_ready),
    .left_channel_audio_out(left_out), .right_channel_audio_out(right_out),
    .write(write), .busy(busy), .drop(drop)
`ifdef EFFECT_SAMPLE_SEQ_COUNT_EN
    , .sample_count(sample_count)
`endif
  );
  always #5 clk = ~clk;
  assign l_fx_out = mode ? l_fx_in ^ 32'h5A5A_0F0F : l_fx_in;
  assign r_fx_out = mode ? r_fx_in + 32'd3 : r_fx_in;
  pair_t adc_q[$], exp_q[$];
  int checks = 0, errors = 0, cyc = 0, rcyc = 0, dut_rd = 0, dut_wr = 0;
  logic inflight = 1'b0, prev_idle = 1'b0, prev_rr = 1'b0, was_read = 1'b0;
  logic [31:0] sc_model = '0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask
  // Reference: a read follows any idle cycle with read_ready; the write window opens PL+1 cycles later and closes TO cycles after that.
  always @(negedge clk) begin
    logic exp_rd, exp_wr, exp_dr;
    pair_t e;
    if (read) dut_rd++;
    if (write) dut_wr++;
    if (reset) begin
      chk("reset_ctrl", {read, write, busy, drop}, 0);
      chk("reset_fx_in", {l_fx_in, r_fx_in}, 0);
      chk("reset_audio_out", {left_out, right_out}, 0);
      if (inflight && exp_q.size() != 0) void'(exp_q.pop_front());
      inflight = 1'b0;
      prev_idle = 1'b0;
      sc_model = '0;
    end else begin
      exp_rd = prev_idle && prev_rr;
      chk("read", read, exp_rd);
      if (exp_rd) begin
        inflight = 1'b1;
        rcyc = cyc;
      end
      exp_wr = inflight && cyc >= rcyc + PL + 1 && write_ready;
      exp_dr = inflight && cyc == rcyc + PL + 1 + TO && !write_ready;
      chk("write", write, exp_wr);
      chk("drop", drop, exp_dr);
      chk("busy", busy, inflight);
      chk("rd_wr_excl", read && write, 0);
`ifdef EFFECT_SAMPLE_SEQ_COUNT_EN
      chk("sample_count", sample_count, sc_model);
`endif
      if (exp_wr || exp_dr) begin
        if (exp_q.size() == 0) chk("scoreboard_empty", 1, 0);
        else begin
          e = exp_q.pop_front();
          if (exp_wr) begin
            chk("audio_out_l", left_out, e.l);
            chk("audio_out_r", right_out, e.r);
            sc_model++;
          end
        end
      end
      prev_idle = !inflight;
      if (exp_wr || exp_dr) inflight = 1'b0;
      prev_rr = read_ready;
    end
  end
  task automatic upd();
    read_ready = adc_q.size() != 0;
    left_in = read_ready ? adc_q[0].l : $urandom;
    right_in = read_ready ? adc_q[0].r : $urandom;
  endtask
  task automatic push(input logic [31:0] l, input logic [31:0] r);
    pair_t p, e;
    p.l = l;
    p.r = r;
    e.l = mode ? l ^ 32'h5A5A_0F0F : l;
    e.r = mode ? r + 32'd3 : r;
    adc_q.push_back(p);
    exp_q.push_back(e);
    upd();
  endtask
  task automatic step();
    @(negedge clk);
    was_read = read;
    @(posedge clk);
    #1;
    if (was_read && adc_q.size() != 0) void'(adc_q.pop_front());
    upd();
  endtask
  task automatic drain(input int max);
    int n = 0;
    while ((adc_q.size() != 0 || exp_q.size() != 0 || busy) && n < max) begin
      step();
      n++;
    end
    chk("drain_timeout", n >= max, 0);
  endtask
  task automatic wait_read(input int max);
    int n = 0;
    was_read = 1'b0;
    while (!was_read && n < max) begin
      step();
      n++;
    end
    chk("read_timeout", was_read, 1);
  endtask
  initial begin
    int b_rd, b_wr;
    repeat (3) step();
    reset = 1'b0;
    write_ready = 1'b1;
    push(32'h1234_5678, 32'hFFFF_0001);
    drain(30);
    write_ready = 1'b0;
    push($urandom, $urandom);
    drain(40);
    push($urandom, $urandom);
    wait_read(20);
    repeat (PL + TO) step();
    write_ready = 1'b1;
    step();
    drain(20);
    push($urandom, $urandom);
    wait_read(20);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    push(32'h8000_0000, 32'h7FFF_FFFF);
    drain(30);
    mode = 1'b1;
    b_rd = dut_rd;
    b_wr = dut_wr;
    for (int i = 0; i < 10; i++) push($urandom, $urandom);
    drain(200);
    chk("b2b_reads", dut_rd - b_rd, 10);
    chk("b2b_writes", dut_wr - b_wr, 10);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) push($urandom, $urandom);
      write_ready = $urandom_range(0, 9) < 7;
      step();
    end
    write_ready = 1'b1;
    drain(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/effect_sample_sequencer.md
EFFECT_SAMPLE_SEQUENCER -- requirements
Module: effect_sample_sequencer

Interface
REQ-001 The block SHALL have parameter PROC_LATENCY, default 2, meaning cycles the effect stage is given to settle; legal range 1..15.
REQ-002 The block SHALL have parameter WR_TIMEOUT, default 1023, meaning the maximum number of cycles to wait for write_ready before dropping a sample pair; legal range 1..65535.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 read_ready  input  1  codec ADC FIFO holds at least one left/right sample pair.
REQ-006 left_channel_audio_in, right_channel_audio_in  input  32 each  signed ADC samples, valid while read_ready=1.
REQ-007 read  output  1  one-cycle pop strobe to the ADC FIFO.
REQ-008 l_fx_in, r_fx_in  output  32 each  held sample pair driven to the effect stage.
REQ-009 l_fx_out, r_fx_out  input  32 each  signed effect-stage result.
REQ-010 write_ready  input  1  codec DAC FIFO has space for one pair.
REQ-011 left_channel_audio_out, right_channel_audio_out  output  32 each  registered result pair to the DAC FIFO.
REQ-012 write  output  1  one-cycle push strobe to the DAC FIFO.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 drop  output  1  one-cycle pulse when a pair is discarded on write timeout.

Function
REQ-015 The FSM SHALL have states IDLE, READ, PROC, WRITE.
REQ-016 IDLE: read_ready=1 at a clock edge -> READ; otherwise stay IDLE.
REQ-017 READ lasts exactly one cycle: read=1; l_fx_in/r_fx_in load left/right inputs at the end of that cycle; -> PROC.
REQ-018 PROC lasts exactly PROC_LATENCY cycles, counted by a 4-bit down-counter; l_fx_in/r_fx_in stay constant.
REQ-019 On the last PROC cycle, l_fx_out/r_fx_out SHALL be registered into left/right_channel_audio_out; -> WRITE.
REQ-020 WRITE: write = (state==WRITE) & write_ready, combinational; on that edge -> IDLE.
REQ-021 WRITE: a 16-bit wait counter increments each cycle with write_ready=0; on reaching WR_TIMEOUT -> IDLE with drop=1 for one cycle and write=0.
REQ-022 read SHALL never assert outside READ; write SHALL never assert outside WRITE; read and write SHALL never both be 1.
REQ-023 Minimum read-to-write spacing SHALL be PROC_LATENCY+1 cycles; minimum full-loop throughput SHALL be one pair per PROC_LATENCY+3 cycles.
REQ-024 Samples SHALL pass unmodified (no width change, sign preserved) between read and write other than via the effect stage.
REQ-025 read_ready dropping during PROC or WRITE SHALL have no effect; it is sampled only in IDLE.
REQ-026 write_ready and the timeout compare both true in the same cycle: the write SHALL win, drop=0.

Reset
REQ-027 On reset=1 the block SHALL immediately enter IDLE, clear all counters, and drive read=0, write=0, busy=0, drop=0, l_fx_in=r_fx_in=0, left/right_channel_audio_out=0.
REQ-028 Reset mid-operation SHALL abandon the pair in flight with no write and no drop pulse.
REQ-029 After reset deasserts, the first READ SHALL occur no earlier than the second rising edge.

Configuration
REQ-030 With macro EFFECT_SAMPLE_SEQ_COUNT_EN defined, the block SHALL add output sample_count (32 bits), reset to 0, incremented on each write strobe, wrapping 0xFFFFFFFF -> 0.
REQ-031 Without EFFECT_SAMPLE_SEQ_COUNT_EN, the sample_count port and counter SHALL not exist; all other behaviour is identical.

Verification
REQ-032 PROC_LATENCY=2, read_ready=1, left=0x12345678, right=0xFFFF0001, pass-through effect, write_ready=1 -> read at cycle 1, write at cycle 4, outputs 0x12345678/0xFFFF0001.
REQ-033 write_ready held 0, WR_TIMEOUT=5 -> no write, drop pulse one cycle after 5 waiting cycles, busy falls next cycle.
REQ-034 write_ready rises on exactly the timeout cycle -> write=1, drop=0.
REQ-035 reset pulsed during PROC -> all outputs 0 immediately, no write, FSM back in IDLE, next pair processed normally.
REQ-036 read_ready continuously 1, write_ready 1, 10 pairs -> exactly 10 read and 10 write strobes, never concurrent, spacing PROC_LATENCY+3; with EFFECT_SAMPLE_SEQ_COUNT_EN, sample_count=10.
